// File: rtl/tile_match_engine.sv
// ============================================================================
// tile_match_engine : registered N-tile reveal/match/score core for the tile game.
// Optional macro BEST_SCORE_EN adds a best_score output (lowest finishing score).
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tile_match_engine #(
  parameter int NUM_TILES    = 10,
  parameter int CODE_W       = 4,
  parameter int SCORE_W      = 8,
  parameter int DELAY_CYCLES = 100_000_000
) (
  input  logic                          CLOCK_50,
  input  logic                          userquit,
  input  logic                          keytobegin,
  input  logic [NUM_TILES-1:0]          sw,
  input  logic [NUM_TILES*CODE_W-1:0]   tile_codes,
  output logic [1:0]                    mode,
  output logic [NUM_TILES-1:0]          tiles_on,
  output logic [CODE_W-1:0]             code_a,
  output logic                          code_a_vld,
  output logic [CODE_W-1:0]             code_b,
  output logic                          code_b_vld,
  output logic [SCORE_W-1:0]            score,
  output logic                          match_p,
  output logic                          miss_p,
`ifdef BEST_SCORE_EN
  output logic [SCORE_W-1:0]            best_score,
`endif
  output logic                          game_over
);

  localparam int CNT_W = $clog2(DELAY_CYCLES + 1);
  localparam int IDX_W = $clog2(NUM_TILES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY_CYCLES - 1);

  typedef enum logic [2:0] {
    S_MENU = 3'd0,
    S_IDLE = 3'd1,
    S_ONE  = 3'd2,
    S_WAIT = 3'd3,
    S_END  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_TILES-1:0] sw_q;
  logic [NUM_TILES-1:0] matched_q, matched_d;
  logic [IDX_W-1:0]     ia_q, ia_d, ib_q, ib_d;
  logic [CODE_W-1:0]    code_a_q, code_a_d, code_b_q, code_b_d;
  logic                 vld_a_q, vld_a_d, vld_b_q, vld_b_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 match_q, match_d, miss_q, miss_d;
`ifdef BEST_SCORE_EN
  logic [SCORE_W-1:0]   best_q, best_d;
`endif

  logic [CODE_W-1:0]    codes_w [NUM_TILES];
  logic [NUM_TILES-1:0] flip_edge, eligible, pair_mask, matched_hit;
  logic                 sel_vld;
  logic [IDX_W-1:0]     sel_idx;
  logic [SCORE_W-1:0]   score_inc;

  function automatic logic [NUM_TILES-1:0] f_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_TILES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  generate
    for (genvar g = 0; g < NUM_TILES; g++) begin : g_codes
      assign codes_w[g] = tile_codes[g*CODE_W +: CODE_W];
    end
  endgenerate

  // The first revealed tile is only excluded while it is actually revealed.
  assign flip_edge   = sw & ~sw_q;
  assign eligible    = flip_edge & ~matched_q & ~(vld_a_q ? f_onehot(ia_q) : '0);
  assign pair_mask   = f_onehot(ia_q) | f_onehot(ib_q);
  assign matched_hit = matched_q | pair_mask;
  assign score_inc   = (score_q == {SCORE_W{1'b1}}) ? score_q : score_q + 1'b1;

  // Descending scan so the lowest eligible index wins.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = NUM_TILES - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    matched_d = matched_q;
    ia_d      = ia_q;
    ib_d      = ib_q;
    code_a_d  = code_a_q;
    code_b_d  = code_b_q;
    vld_a_d   = vld_a_q;
    vld_b_d   = vld_b_q;
    score_d   = score_q;
    cnt_d     = cnt_q;
    match_d   = 1'b0;
    miss_d    = 1'b0;
`ifdef BEST_SCORE_EN
    best_d    = best_q;
`endif
    case (state_q)
      S_MENU, S_END: begin
        if (keytobegin) begin
          state_d   = S_IDLE;
          matched_d = '0;
          score_d   = '0;
          vld_a_d   = 1'b0;
          vld_b_d   = 1'b0;
        end
      end
      S_IDLE: begin
        if (sel_vld) begin
          state_d  = S_ONE;
          ia_d     = sel_idx;
          code_a_d = codes_w[sel_idx];
          vld_a_d  = 1'b1;
        end
      end
      S_ONE: begin
        if (sel_vld) begin
          state_d  = S_WAIT;
          ib_d     = sel_idx;
          code_b_d = codes_w[sel_idx];
          vld_b_d  = 1'b1;
          cnt_d    = '0;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          score_d = score_inc;
          vld_a_d = 1'b0;
          vld_b_d = 1'b0;
          if (code_a_q == code_b_q) begin
            matched_d = matched_hit;
            match_d   = 1'b1;
          end else begin
            miss_d    = 1'b1;
          end
          if (&matched_d) begin
            state_d = S_END;
`ifdef BEST_SCORE_EN
            if (score_inc < best_q) best_d = score_inc;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_MENU;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge userquit) begin
    if (userquit) begin
      state_q   <= S_MENU;
      sw_q      <= '0;
      matched_q <= '0;
      ia_q      <= '0;
      ib_q      <= '0;
      code_a_q  <= '0;
      code_b_q  <= '0;
      vld_a_q   <= 1'b0;
      vld_b_q   <= 1'b0;
      score_q   <= '0;
      cnt_q     <= '0;
      match_q   <= 1'b0;
      miss_q    <= 1'b0;
`ifdef BEST_SCORE_EN
      best_q    <= '1;
`endif
    end else begin
      state_q   <= state_d;
      sw_q      <= sw;
      matched_q <= matched_d;
      ia_q      <= ia_d;
      ib_q      <= ib_d;
      code_a_q  <= code_a_d;
      code_b_q  <= code_b_d;
      vld_a_q   <= vld_a_d;
      vld_b_q   <= vld_b_d;
      score_q   <= score_d;
      cnt_q     <= cnt_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
`ifdef BEST_SCORE_EN
      best_q    <= best_d;
`endif
    end
  end

  always_comb begin
    case (state_q)
      S_IDLE, S_ONE, S_WAIT: mode = 2'd1;
      S_END:                 mode = 2'd2;
      default:               mode = 2'd0;
    endcase
  end

  assign tiles_on   = matched_q | (vld_a_q ? f_onehot(ia_q) : '0)
                                | (vld_b_q ? f_onehot(ib_q) : '0);
  assign code_a     = code_a_q;
  assign code_a_vld = vld_a_q;
  assign code_b     = code_b_q;
  assign code_b_vld = vld_b_q;
  assign score      = score_q;
  assign match_p    = match_q;
  assign miss_p     = miss_q;
  assign game_over  = (state_q == S_END);
`ifdef BEST_SCORE_EN
  assign best_score = best_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tile_match_engine.sv
// ============================================================================
// tb_tile_match_engine : scoreboard bench, 4 tiles with codes {3,1,3,1} (tile 3..0).
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tile_match_engine;

  localparam int NT = 4;
  localparam int CW = 4;
  localparam int SW = 8;
  localparam int DL = 4;

  localparam int K_A = 0, K_B = 1, K_MATCH = 2, K_MISS = 3, K_END = 4;

  logic           clk = 1'b0;
  logic           userquit = 1'b0;
  logic           keytobegin = 1'b0;
  logic [NT-1:0]  sw = '0;
  logic [NT*CW-1:0] tile_codes = {4'd3, 4'd1, 4'd3, 4'd1};
  logic [1:0]     mode;
  logic [NT-1:0]  tiles_on;
  logic [CW-1:0]  code_a, code_b;
  logic           code_a_vld, code_b_vld, match_p, miss_p, game_over;
  logic [SW-1:0]  score;
`ifdef BEST_SCORE_EN
  logic [SW-1:0]  best_score;
`endif

  tile_match_engine #(
    .NUM_TILES(NT), .CODE_W(CW), .SCORE_W(SW), .DELAY_CYCLES(DL)
  ) dut (
    .CLOCK_50(clk), .userquit(userquit), .keytobegin(keytobegin), .sw(sw),
    .tile_codes(tile_codes), .mode(mode), .tiles_on(tiles_on),
    .code_a(code_a), .code_a_vld(code_a_vld), .code_b(code_b), .code_b_vld(code_b_vld),
    .score(score), .match_p(match_p), .miss_p(miss_p),
`ifdef BEST_SCORE_EN
    .best_score(best_score),
`endif
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    int        kind;
    logic [3:0] ca;
    logic [3:0] cb;
    logic [3:0] tiles;
    logic [7:0] sc;
    logic [1:0] md;
    logic [7:0] best;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [3:0] ca, input logic [3:0] cb,
                      input logic [3:0] tiles, input logic [7:0] sc, input logic [1:0] md,
                      input logic [7:0] best);
    exp_t e;
    e.kind = k; e.ca = ca; e.cb = cb; e.tiles = tiles; e.sc = sc; e.md = md; e.best = best;
    q.push_back(e);
  endtask

  task automatic do_event(input int kind);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event actual=kind%0d required=none", kind);
    end else begin
      e = q.pop_front();
      chk("evt_kind", kind, e.kind);
      chk("evt_tiles_on", tiles_on, e.tiles);
      chk("evt_score", score, e.sc);
      chk("evt_mode", mode, e.md);
      if (kind == K_A || kind == K_B) chk("evt_code_a", code_a, e.ca);
      if (kind == K_B) chk("evt_code_b", code_b, e.cb);
      if (kind == K_END) begin
        chk("evt_game_over", game_over, 1);
`ifdef BEST_SCORE_EN
        chk("evt_best_score", best_score, e.best);
`endif
      end
    end
  endtask

  // Monitor: reacts to DUT output events, independent of the stimulus flow.
  initial begin
    logic pa, pb, pg;
    int   hold;
    pa = 0; pb = 0; pg = 0; hold = 0;
    forever begin
      @(negedge clk);
      if (userquit) begin
        pa = 0; pb = 0; pg = 0; hold = 0;
      end else begin
        if (code_a_vld && !pa) do_event(K_A);
        if (code_b_vld && !pb) do_event(K_B);
        if (match_p)           do_event(K_MATCH);
        if (miss_p)            do_event(K_MISS);
        if (game_over && !pg)  do_event(K_END);
        if (code_b_vld) hold++;
        else if (pb) begin
          chk("code_b_vld_hold", hold, DL);
          hold = 0;
        end
        pa = code_a_vld; pb = code_b_vld; pg = game_over;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_game();
    keytobegin = 1'b1;
    step(1);
    keytobegin = 1'b0;
    step(1);
  endtask

  initial begin
    #2 userquit = 1'b1;
    step(2);
    chk("rst_mode", mode, 0);
    chk("rst_tiles_on", tiles_on, 0);
    chk("rst_score", score, 0);
    chk("rst_codes", {code_a, code_b}, 0);
    chk("rst_vld", {code_a_vld, code_b_vld}, 0);
    chk("rst_pulses", {match_p, miss_p, game_over}, 0);
`ifdef BEST_SCORE_EN
    chk("rst_best", best_score, 8'hff);
`endif
    userquit = 1'b0;
    step(2);
    chk("menu_hold_mode", mode, 0);

    // Game 1: mismatch, held switch, match, reselect, final match -> END with 3 moves
    start_game();
    chk("g1_mode_play", mode, 1);
    push(K_A, 4'd1, 4'd0, 4'b0001, 8'd0, 2'd1, 8'd0);
    sw[0] = 1'b1; step(3);
    push(K_B, 4'd1, 4'd3, 4'b0011, 8'd0, 2'd1, 8'd0);
    push(K_MISS, 4'd0, 4'd0, 4'b0000, 8'd1, 2'd1, 8'd0);
    sw[1] = 1'b1; step(8);
    sw[1] = 1'b0; step(4);
    chk("held_sw0_no_reveal", code_a_vld, 0);
    chk("held_sw0_tiles", tiles_on, 4'b0000);

    sw[0] = 1'b0; step(2);
    push(K_A, 4'd1, 4'd0, 4'b0001, 8'd1, 2'd1, 8'd0);
    sw[0] = 1'b1; step(3);
    push(K_B, 4'd1, 4'd1, 4'b0101, 8'd1, 2'd1, 8'd0);
    push(K_MATCH, 4'd0, 4'd0, 4'b0101, 8'd2, 2'd1, 8'd0);
    sw[2] = 1'b1; step(8);

    push(K_A, 4'd3, 4'd0, 4'b0111, 8'd2, 2'd1, 8'd0);
    sw[1] = 1'b1; step(3);
    sw[1] = 1'b0; step(2);
    sw[1] = 1'b1; step(3);
    sw[0] = 1'b0; step(1);
    sw[0] = 1'b1; step(3);
    chk("reselect_ignored_vld_b", code_b_vld, 0);
    chk("reselect_ignored_tiles", tiles_on, 4'b0111);

    push(K_B, 4'd3, 4'd3, 4'b1111, 8'd2, 2'd1, 8'd0);
    push(K_MATCH, 4'd0, 4'd0, 4'b1111, 8'd3, 2'd2, 8'd0);
    push(K_END, 4'd0, 4'd0, 4'b1111, 8'd3, 2'd2, 8'd3);
    sw[3] = 1'b1; step(8);
    chk("g1_end_mode", mode, 2);

    sw = '0; step(2);
    start_game();
    chk("g2_fresh_score", score, 0);
    chk("g2_fresh_tiles", tiles_on, 0);
    chk("g2_fresh_game_over", game_over, 0);

    // Game 2: simultaneous rise on tiles 1 and 3, then finish in 2 moves
    push(K_A, 4'd3, 4'd0, 4'b0010, 8'd0, 2'd1, 8'd0);
    sw = 4'b1010; step(4);
    chk("simul_tile3_dark", tiles_on, 4'b0010);
    chk("simul_no_second", code_b_vld, 0);
    sw[3] = 1'b0; step(2);
    push(K_B, 4'd3, 4'd3, 4'b1010, 8'd0, 2'd1, 8'd0);
    push(K_MATCH, 4'd0, 4'd0, 4'b1010, 8'd1, 2'd1, 8'd0);
    sw[3] = 1'b1; step(8);
    push(K_A, 4'd1, 4'd0, 4'b1011, 8'd1, 2'd1, 8'd0);
    sw[0] = 1'b1; step(3);
    push(K_B, 4'd1, 4'd1, 4'b1111, 8'd1, 2'd1, 8'd0);
    push(K_MATCH, 4'd0, 4'd0, 4'b1111, 8'd2, 2'd2, 8'd0);
    push(K_END, 4'd0, 4'd0, 4'b1111, 8'd2, 2'd2, 8'd2);
    sw[2] = 1'b1; step(8);

    sw = '0; step(2);
    start_game();
    chk("g3_fresh_score", score, 0);
    chk("g3_mode_play", mode, 1);

    // Asynchronous quit while the second tile is held
    push(K_A, 4'd1, 4'd0, 4'b0001, 8'd0, 2'd1, 8'd0);
    sw[0] = 1'b1; step(3);
    push(K_B, 4'd1, 4'd1, 4'b0101, 8'd0, 2'd1, 8'd0);
    sw[2] = 1'b1; step(2);
    chk("mid_wait_vld_b", code_b_vld, 1);
    #2 userquit = 1'b1;
    #1;
    chk("async_quit_mode", mode, 0);
    chk("async_quit_tiles", tiles_on, 0);
    chk("async_quit_score", score, 0);
    chk("async_quit_vld", {code_a_vld, code_b_vld}, 0);
`ifdef BEST_SCORE_EN
    chk("async_quit_best", best_score, 8'hff);
`endif
    step(2);
    userquit = 1'b0;
    step(4);
    chk("pending_events", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
